// File: rtl/rtc_secuenciador.sv
// rtc_secuenciador: reads the eight RTC time fields, then streams them framed by inicioSecuencia
module rtc_secuenciador #(
  parameter logic [7:0] BASE_ADDR   = 8'h21,
  parameter int         PRE_CICLOS  = 10,
  parameter int         POST_CICLOS = 3,
  parameter int         TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_actualizar,
  output logic       rtc_rd,
  output logic [7:0] rtc_addr,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_dato,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       ocupado,
  output logic       error_timeout
);
  typedef enum logic [2:0] {IDLE, LEER, ESPERA, PRE, ENVIAR, POST} estado_t;
  estado_t         est_q, est_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            pend_q, pend_d, err_q, err_d, wr;
  logic [7:0][7:0] buf_q;
  // next-state: one shared counter times the ack wait, the PRE/POST frames and the byte slot
  always_comb begin
    est_d  = est_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q + 16'd1;
    pend_d = pend_q | (tick_actualizar && est_q != IDLE);
    err_d  = err_q;
    wr     = 1'b0;
    case (est_q)
      IDLE: begin
        cnt_d = '0;
        if (tick_actualizar || pend_q) begin
          est_d  = LEER;
          idx_d  = '0;
          pend_d = 1'b0;
        end
      end
      LEER: begin
        if (rtc_ack) begin
          wr    = 1'b1;
          est_d = ESPERA;
          cnt_d = '0;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          est_d = IDLE;
          err_d = 1'b1;
          cnt_d = '0;
        end
      end
      ESPERA: begin
        cnt_d = '0;
        est_d = (idx_q == 3'd7) ? PRE : LEER;
        idx_d = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
        err_d = (idx_q == 3'd7) ? 1'b0 : err_q;
      end
      PRE: if (cnt_q == 16'(PRE_CICLOS - 1)) begin
        est_d = ENVIAR;
        cnt_d = '0;
      end
      ENVIAR: if (cnt_q == 16'd7) begin
        est_d = POST;
        cnt_d = '0;
      end
      POST: if (cnt_q == 16'(POST_CICLOS - 1)) begin
        est_d = IDLE;
        cnt_d = '0;
      end
      default: est_d = IDLE;
    endcase
  end
  // state and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est_q  <= IDLE;
      idx_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      est_q  <= est_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
  // field buffer, written only on an acknowledged read so a failed refresh never streams
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buf_q <= '0;
    else if (wr) buf_q[idx_q] <= rtc_dato;
  end
  // outputs decoded from state so reset forces them immediately
  always_comb begin
    rtc_rd          = est_q == LEER;
    rtc_addr        = BASE_ADDR + {5'd0, idx_q};
    inicioSecuencia = est_q == PRE || est_q == ENVIAR || est_q == POST;
    datoRTC         = est_q == ENVIAR ? buf_q[cnt_q[2:0]] : est_q == POST ? buf_q[7] : 8'h00;
    ocupado         = est_q != IDLE;
    error_timeout   = err_q;
  end
endmodule

// File: tb/tb_rtc_secuenciador.sv
// tb_rtc_secuenciador: directed checks of read sequencing, streaming, timeout, pending ticks and reset
module tb_rtc_secuenciador;
  logic       clk, reset, tick, rtc_rd, rtc_ack, ini, ocupado, err;
  logic [7:0] rtc_addr, rtc_dato, dato;
  int         checks = 0, errors = 0;
  int         delay = 2;
  logic [7:0] noack = 8'hff;
  logic [7:0] mem [8] = '{8'd24, 8'd4, 8'd3, 8'd23, 8'd12, 8'd17, 8'd5, 8'd4};
  int         busy, rd_cyc, rises;
  logic [7:0] stream [$];
  logic [7:0] addrs [$];
  logic       prev_rd = 1'b0, prev_ini = 1'b0;

  rtc_secuenciador dut (
    .clk(clk), .reset(reset), .tick_actualizar(tick), .rtc_rd(rtc_rd), .rtc_addr(rtc_addr),
    .rtc_ack(rtc_ack), .rtc_dato(rtc_dato), .inicioSecuencia(ini), .datoRTC(dato),
    .ocupado(ocupado), .error_timeout(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    busy = 0; rd_cyc = 0; rises = 0;
    stream.delete();
    addrs.delete();
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (ocupado && n < 3000);
    chk(tag, {31'd0, ocupado}, 32'd0);
  endtask

  task automatic wait_inicio(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ini && n < 3000);
    chk(tag, {31'd0, ini}, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] exp [$];
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(8'h00);
    for (int i = 0; i < 8; i++) exp.push_back(mem[i]);
    for (int i = 0; i < 3; i++) exp.push_back(mem[7]);
    chk({tag, "_len"}, stream.size(), 21);
    for (int i = 0; i < 21 && i < stream.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, stream[i]}, {24'd0, exp[i]});
    chk({tag, "_naddr"}, addrs.size(), 8);
    for (int i = 0; i < 8 && i < addrs.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), {24'd0, addrs[i]}, 32'h21 + i);
    chk({tag, "_rises"}, rises, 1);
    chk({tag, "_dato_end"}, {24'd0, dato}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rd"}, {31'd0, rtc_rd}, 32'd0);
    chk({tag, "_addr"}, {24'd0, rtc_addr}, 32'h21);
    chk({tag, "_ini"}, {31'd0, ini}, 32'd0);
    chk({tag, "_dato"}, {24'd0, dato}, 32'd0);
    chk({tag, "_ocup"}, {31'd0, ocupado}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // RTC model: ack `delay` cycles after rtc_rd rises, never for address noack
  initial begin
    int wcnt = 0;
    logic [7:0] off;
    rtc_ack = 1'b0;
    rtc_dato = 8'h00;
    forever begin
      @(negedge clk);
      off = rtc_addr - 8'h21;
      if (rtc_rd) begin
        rtc_ack = wcnt == delay && rtc_addr != noack;
        rtc_dato = rtc_ack ? mem[off[2:0]] : 8'h00;
        wcnt++;
      end else begin
        rtc_ack = 1'b0;
        rtc_dato = 8'h00;
        wcnt = 0;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ocupado) busy++;
      if (rtc_rd) rd_cyc++;
      if (rtc_rd && !prev_rd) addrs.push_back(rtc_addr);
      if (ini) stream.push_back(dato);
      if (ini && !prev_ini) rises++;
      prev_rd = rtc_rd;
      prev_ini = ini;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    reset = 1'b1;
    clear_mon();
    // nominal, ack 2 cycles after rd
    pulse_tick();
    wait_idle("nom_idle");
    check_stream("nom");
    chk("nom_busy", busy, 8 * 4 + 21);
    // zero-latency ack
    delay = 0;
    clear_mon();
    pulse_tick();
    wait_idle("zl_idle");
    check_stream("zl");
    chk("zl_busy", busy, 8 * 2 + 21);
    chk("zl_rdcyc", rd_cyc, 8);
    // timeout on address 23h
    noack = 8'h23;
    clear_mon();
    pulse_tick();
    wait_idle("to_idle");
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rises", rises, 0);
    chk("to_rdcyc", rd_cyc, 1 + 1 + 255);
    chk("to_busy", busy, 2 + 2 + 255);
    chk("to_rd", {31'd0, rtc_rd}, 32'd0);
    // recovery clears the flag on PRE entry
    noack = 8'hff;
    clear_mon();
    pulse_tick();
    chk("rec_err_held", {31'd0, err}, 32'd1);
    wait_inicio("rec_ini");
    chk("rec_err_clr", {31'd0, err}, 32'd0);
    wait_idle("rec_idle");
    // three ticks during ENVIAR merge into one pending refresh
    clear_mon();
    pulse_tick();
    wait_inicio("pd_ini");
    repeat (12) @(negedge clk);
    repeat (3) pulse_tick();
    wait_idle("pd_idle1");
    @(negedge clk);
    chk("pd_restart", {31'd0, ocupado}, 32'd1);
    // tick on the cycle POST exits is kept pending
    wait_inicio("pd_ini2");
    repeat (20) @(negedge clk);
    chk("pd_post_last", {31'd0, ini}, 32'd1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("pd_gap", {31'd0, ocupado}, 32'd0);
    @(negedge clk);
    chk("pd_restart2", {31'd0, ocupado}, 32'd1);
    wait_idle("pd_idle3");
    repeat (30) @(negedge clk);
    chk("pd_quiet", {31'd0, ocupado}, 32'd0);
    chk("pd_rises", rises, 3);
    chk("pd_len", stream.size(), 63);
    // reset in the 4th ENVIAR cycle
    pulse_tick();
    wait_inicio("rm_ini");
    repeat (13) @(negedge clk);
    chk("rm_byte3", {24'd0, dato}, {24'd0, mem[3]});
    #2 reset = 1'b0;
    #1 check_reset_outs("rm");
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    chk("rm_quiet", {31'd0, ocupado}, 32'd0);
    chk("rm_rises", rises, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtc_secuenciador.md
RTC_SECUENCIADOR -- requirements
Module: rtc_secuenciador

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h21: RTC register address of seconds; the remaining seven fields follow at BASE_ADDR+1..+7.
REQ-002 SHALL have parameter PRE_CICLOS, default 10: cycles inicioSecuencia is high before the first byte.
REQ-003 SHALL have parameter POST_CICLOS, default 3: cycles inicioSecuencia stays high after the last byte.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for rtc_ack on one read.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 tick_actualizar  input  1  one-cycle pulse that requests a refresh (once per frame).
REQ-008 rtc_rd  output  1  read request to the RTC access block.
REQ-009 rtc_addr  output  8  register address for the current read.
REQ-010 rtc_ack  input  1  read acknowledge; rtc_dato is valid in the same cycle.
REQ-011 rtc_dato  input  8  read data from the RTC.
REQ-012 inicioSecuencia  output  1  frames the 8-byte stream to the display interface.
REQ-013 datoRTC  output  8  streamed byte.
REQ-014 ocupado  output  1  high in every state except IDLE.
REQ-015 error_timeout  output  1  sticky flag: the last read attempt timed out.

Function
REQ-016 SHALL implement the states IDLE, LEER, ESPERA, PRE, ENVIAR and POST.
REQ-017 IDLE: on tick_actualizar=1 (or pendiente=1), SHALL clear the field index to 0 and go to LEER.
REQ-018 LEER:
- SHALL drive rtc_rd=1 and rtc_addr=BASE_ADDR+index, held stable until rtc_ack is sampled high.
- On rtc_ack=1, SHALL store rtc_dato in buffer[index] on that edge and go to ESPERA.
REQ-019 ESPERA: SHALL drive rtc_rd=0 for exactly one cycle, then:
- if index<7: increment index, go to LEER;
- if index=7: go to PRE.
REQ-020 Buffer order SHALL be seconds, minutes, hours, date, month, year, day, week (index 0..7).
REQ-021 Timeout: if rtc_ack stays 0 for TIMEOUT consecutive cycles in LEER, SHALL:
- deassert rtc_rd;
- set error_timeout=1;
- return to IDLE with no stream emitted (inicioSecuencia never rises).
REQ-022 PRE: SHALL drive inicioSecuencia=1 and datoRTC=8'h00 for exactly PRE_CICLOS cycles.
REQ-023 ENVIAR: SHALL output buffer[0..7] on datoRTC in 8 consecutive cycles, one byte per cycle, with inicioSecuencia=1.
REQ-024 POST: SHALL hold inicioSecuencia=1 with datoRTC=buffer[7] for POST_CICLOS cycles, then:
- drive inicioSecuencia=0 and datoRTC=8'h00;
- go to IDLE.
REQ-025 error_timeout SHALL be cleared on entry to PRE, i.e. after a complete successful read of all 8 fields.
REQ-026 Total latency SHALL be 8 reads + PRE_CICLOS + 8 + POST_CICLOS cycles, where one read = (cycles to ack + 1) cycles.
REQ-027 The stream SHALL never begin until all 8 fields of the current refresh have been read; no mix of old and new fields is ever streamed.
REQ-028 tick_actualizar while ocupado=1 SHALL set pendiente; at most one pending request is kept, and further ticks are merged into it.
REQ-029 pendiente SHALL be cleared when the pending refresh starts from IDLE.
REQ-030 tick_actualizar arriving in the same cycle that POST exits SHALL be kept as pendiente.
REQ-031 rtc_ack outside LEER SHALL be ignored.
REQ-032 Index arithmetic SHALL be 3-bit; rtc_addr = BASE_ADDR + index, computed mod 256.

Reset
REQ-033 While reset=0, SHALL asynchronously force:
- state=IDLE, index=0, pendiente=0;
- all 8 buffer bytes=0;
- rtc_rd=0, rtc_addr=BASE_ADDR;
- inicioSecuencia=0, datoRTC=8'h00;
- ocupado=0, error_timeout=0.
REQ-034 Reset asserted mid-read or mid-stream SHALL abort immediately; after release, no stream resumes without a new tick_actualizar.

Verification
REQ-035 Nominal read and stream:
- Stimulus: tick; RTC acks each read 2 cycles after rtc_rd rises, returning 24, 4, 3, 23, 12, 17, 5, 4.
- Response: rtc_addr steps 21h..28h; inicioSecuencia high for 10 cycles with datoRTC=00; then 24, 4, 3, 23, 12, 17, 5, 4 on consecutive cycles; then 3 cycles holding 4; then inicioSecuencia=0 and datoRTC=0.
REQ-036 Timeout: the RTC never acks address 23h -> rtc_rd drops after 255 cycles, error_timeout=1, inicioSecuencia stays 0. A later fully acked refresh clears error_timeout at PRE entry.
REQ-037 Ticks while busy: three ticks during ENVIAR -> exactly one additional full refresh starts after POST exits, and pendiente=0 afterwards.
REQ-038 Reset mid-stream: reset=0 during the 4th ENVIAR cycle -> all outputs go to reset values immediately; after release, outputs stay idle until the next tick.
REQ-039 Zero-latency ack: rtc_ack=1 in the first LEER cycle of every read -> each read takes exactly 2 cycles (LEER + ESPERA), and rtc_rd shows a 1-cycle low gap between reads.
